// File: rtl/line_buffer_3row.sv
// ---------------------------------------------------------------------------
// line_buffer_3row
//
// Turns a raster-order pixel stream into three vertically aligned taps for
// the 3x3 window stage. Two line memories hold the previous two lines, so
// each accepted pixel comes out together with the pixels directly above it.
//
// Parameters
//   DATA_W      pixel width in bits
//   IMG_WIDTH   pixels per line (>=3)
//   IMG_HEIGHT  lines per frame (>=3)
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous reset, active low (0 = reset)
//   in_valid     in_pixel / sof are valid this cycle
//   sof          start of frame, marks pixel (0,0); qualified by in_valid
//   in_pixel     input pixel
//   row0         current-line tap
//   row1         tap one line up, same column
//   row2         tap two lines up, same column
//   pixel_valid  taps valid this cycle (window stage shift enable)
//   win_valid    this tap completes a full 3x3 window (row>=2 && col>=2)
//   col_idx      column of the pixel now on row0
//   row_idx      line of the pixel now on row0
//   frame_done   one-cycle pulse in the cycle after the last tap of a frame
// ---------------------------------------------------------------------------
module line_buffer_3row #(
  parameter int DATA_W     = 8,
  parameter int IMG_WIDTH  = 28,
  parameter int IMG_HEIGHT = 28
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  input  logic                          sof,
  input  logic [DATA_W-1:0]             in_pixel,
  output logic [DATA_W-1:0]             row0,
  output logic [DATA_W-1:0]             row1,
  output logic [DATA_W-1:0]             row2,
  output logic                          pixel_valid,
  output logic                          win_valid,
  output logic [$clog2(IMG_WIDTH)-1:0]  col_idx,
  output logic [$clog2(IMG_HEIGHT)-1:0] row_idx,
  output logic                          frame_done
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [RW-1:0] ROW_ONE  = RW'(1);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    STREAM,
    DONE
  } state_t;

  state_t state;

  // Position of the next pixel to be written
  logic [CW-1:0] col_cnt;
  logic [RW-1:0] row_cnt;

  // lb0 holds the previous line, lb1 the line before that
  logic [DATA_W-1:0] lb0 [IMG_WIDTH];
  logic [DATA_W-1:0] lb1 [IMG_WIDTH];

  logic              in_frame;
  logic              accept;
  logic [CW-1:0]     eff_col;
  logic [RW-1:0]     eff_row;
  logic              col_last;
  logic              row_last;
  logic [DATA_W-1:0] lb0_rd;
  logic [DATA_W-1:0] lb1_rd;

  // sof always wins: it (re)starts a frame at (0,0) from any state, so the
  // effective coordinates of the accepted pixel ignore the counters then.
  always_comb begin
    in_frame = (state == FILL) || (state == STREAM);
    accept   = in_valid && (sof || in_frame);
    eff_col  = sof ? '0 : col_cnt;
    eff_row  = sof ? '0 : row_cnt;
    col_last = (eff_col == COL_LAST);
    row_last = (eff_row == ROW_LAST);
    lb0_rd   = lb0[eff_col];
    lb1_rd   = lb1[eff_col];
  end

  // Line memories: no reset, contents only matter once two lines of the
  // current frame have been written. Reads above see the pre-write value.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb0[eff_col] <= in_pixel;
      lb1[eff_col] <= lb0_rd;
    end
  end

  // Control FSM, counters and registered tap outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      col_cnt     <= '0;
      row_cnt     <= '0;
      row0        <= '0;
      row1        <= '0;
      row2        <= '0;
      pixel_valid <= 1'b0;
      win_valid   <= 1'b0;
      col_idx     <= '0;
      row_idx     <= '0;
      frame_done  <= 1'b0;
    end else begin
      pixel_valid <= accept;
      win_valid   <= accept && (eff_row >= ROW_TWO) && (eff_col >= COL_TWO);
      // DONE lasts exactly one cycle, the one right after the last tap
      frame_done  <= (state == DONE);

      if (accept) begin
        row0    <= in_pixel;
        row1    <= lb0_rd;
        row2    <= lb1_rd;
        col_idx <= eff_col;
        row_idx <= eff_row;

        if (col_last) begin
          col_cnt <= '0;
          row_cnt <= row_last ? '0 : eff_row + 1'b1;
        end else begin
          col_cnt <= eff_col + 1'b1;
          row_cnt <= eff_row;
        end

        if (col_last && row_last) begin
          state <= DONE;
        end else if (col_last && (eff_row == ROW_ONE)) begin
          state <= STREAM;
        end else if (sof) begin
          state <= FILL;
        end
      end else if (state == DONE) begin
        state <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_line_buffer_3row.sv
// ---------------------------------------------------------------------------
// tb_line_buffer_3row
//
// Directed bench for line_buffer_3row with a 4x4 image. Each accepted pixel
// pushes its expected tap onto a scoreboard queue; a monitor process pops
// and compares whenever the DUT raises pixel_valid.
// ---------------------------------------------------------------------------
module tb_line_buffer_3row;

  localparam int W  = 4;
  localparam int H  = 4;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          sof;
  logic [DW-1:0] in_pixel;
  logic [DW-1:0] row0;
  logic [DW-1:0] row1;
  logic [DW-1:0] row2;
  logic          pixel_valid;
  logic          win_valid;
  logic [1:0]    col_idx;
  logic [1:0]    row_idx;
  logic          frame_done;

  line_buffer_3row #(
    .DATA_W    (DW),
    .IMG_WIDTH (W),
    .IMG_HEIGHT(H)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .sof        (sof),
    .in_pixel   (in_pixel),
    .row0       (row0),
    .row1       (row1),
    .row2       (row2),
    .pixel_valid(pixel_valid),
    .win_valid  (win_valid),
    .col_idx    (col_idx),
    .row_idx    (row_idx),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] r0;
    logic [DW-1:0] r1;
    logic [DW-1:0] r2;
    bit            k1;
    bit            k2;
    int            col;
    int            row;
    bit            win;
    bit            last;
  } tap_t;

  tap_t          sb[$];
  logic [DW-1:0] img [H][W];

  int checks = 0;
  int errors = 0;

  // Bench-side frame tracking
  bit active = 1'b0;
  int mr = 0;
  int mc = 0;

  // Monitor statistics
  int            fd_count  = 0;
  int            win_count = 0;
  int            pv_count  = 0;
  bit            fd_pending = 1'b0;
  logic [DW-1:0] hold_row0 = '0;
  int            hold_col  = 0;
  int            hold_row  = 0;

  int fd0, win0, pv0;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Drive one cycle of input; record the expected tap if it should be accepted
  task automatic applyStimulus(input bit v, input bit s, input logic [DW-1:0] pix);
    tap_t e;
    in_valid = v;
    sof      = s;
    in_pixel = pix;
    if (v && (s || active)) begin
      if (s) begin
        mr = 0;
        mc = 0;
        active = 1'b1;
      end
      e.r0   = pix;
      e.k1   = (mr >= 1);
      e.k2   = (mr >= 2);
      e.r1   = e.k1 ? img[mr-1][mc] : '0;
      e.r2   = e.k2 ? img[mr-2][mc] : '0;
      e.col  = mc;
      e.row  = mr;
      e.win  = (mr >= 2) && (mc >= 2);
      e.last = (mr == H-1) && (mc == W-1);
      img[mr][mc] = pix;
      sb.push_back(e);
      if (e.last) begin
        active = 1'b0;
        mr = 0;
        mc = 0;
      end else if (mc == W-1) begin
        mc = 0;
        mr++;
      end else begin
        mc++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic sendFrame(input int base, input bit gaps);
    for (int i = 0; i < W*H; i++) begin
      applyStimulus(1'b1, i == 0, DW'(base + i));
      if (gaps) applyStimulus(1'b0, 1'b0, DW'($urandom));
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 10 && sb.size() != 0; i++) applyStimulus(1'b0, 1'b0, '0);
    repeat (2) applyStimulus(1'b0, 1'b0, '0);
    checkOutput("drain", 32'(sb.size()), 32'd0);
  endtask

  task automatic monitorLoop();
    tap_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        sb.delete();
        fd_pending = 1'b0;
        hold_row0  = '0;
        hold_col   = 0;
        hold_row   = 0;
      end else begin
        checkOutput("frame_done", 32'(frame_done), 32'(fd_pending));
        if (frame_done === 1'b1) fd_count++;
        fd_pending = 1'b0;
        if (pixel_valid === 1'b1) begin
          pv_count++;
          if (win_valid === 1'b1) win_count++;
          if (sb.size() == 0) begin
            checkOutput("unexpected_tap", 32'(pixel_valid), 32'd0);
          end else begin
            e = sb.pop_front();
            checkOutput("row0", 32'(row0), 32'(e.r0));
            if (e.k1) checkOutput("row1", 32'(row1), 32'(e.r1));
            if (e.k2) checkOutput("row2", 32'(row2), 32'(e.r2));
            checkOutput("col_idx", 32'(col_idx), 32'(e.col));
            checkOutput("row_idx", 32'(row_idx), 32'(e.row));
            checkOutput("win_valid", 32'(win_valid), 32'(e.win));
            fd_pending = e.last;
            hold_row0  = e.r0;
            hold_col   = e.col;
            hold_row   = e.row;
          end
        end else begin
          checkOutput("win_idle", 32'(win_valid), 32'd0);
          checkOutput("row0_hold", 32'(row0), 32'(hold_row0));
          checkOutput("col_hold", 32'(col_idx), 32'(hold_col));
          checkOutput("row_hold", 32'(row_idx), 32'(hold_row));
        end
      end
    end
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    sof      = 1'b0;
    in_pixel = '0;
    #1 rst = 1'b0;
    fork
      monitorLoop();
    join_none
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    #1;

    // Test 1: asynchronous reset in the middle of a frame
    $display("[TB] test 1: mid-frame reset");
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, i == 0, DW'(30 + i));
    in_valid = 1'b0;
    #1 rst = 1'b0;
    active = 1'b0;
    #1;
    checkOutput("rst_pixel_valid", 32'(pixel_valid), 32'd0);
    checkOutput("rst_row0", 32'(row0), 32'd0);
    checkOutput("rst_row1", 32'(row1), 32'd0);
    checkOutput("rst_row2", 32'(row2), 32'd0);
    checkOutput("rst_col_idx", 32'(col_idx), 32'd0);
    checkOutput("rst_row_idx", 32'(row_idx), 32'd0);
    checkOutput("rst_win_valid", 32'(win_valid), 32'd0);
    checkOutput("rst_frame_done", 32'(frame_done), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    #1;

    // Test 4: no sof after reset, every pixel dropped
    $display("[TB] test 4: pixels without sof are dropped");
    pv0 = pv_count;
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b0, DW'(90 + i));
    applyStimulus(1'b0, 1'b0, '0);
    checkOutput("no_sof_taps", 32'(pv_count - pv0), 32'd0);

    // Test 2: continuous frame, then pixels dropped in DONE and IDLE
    $display("[TB] test 2: continuous frame");
    fd0 = fd_count; win0 = win_count;
    sendFrame(0, 1'b0);
    applyStimulus(1'b1, 1'b0, 8'hAA);
    applyStimulus(1'b1, 1'b0, 8'hBB);
    drain();
    checkOutput("t2_win_count", 32'(win_count - win0), 32'd4);
    checkOutput("t2_frame_done", 32'(fd_count - fd0), 32'd1);

    // Test 3: same frame with a gap after every pixel
    $display("[TB] test 3: frame with gaps");
    fd0 = fd_count; win0 = win_count;
    sendFrame(0, 1'b1);
    drain();
    checkOutput("t3_win_count", 32'(win_count - win0), 32'd4);
    checkOutput("t3_frame_done", 32'(fd_count - fd0), 32'd1);

    // Test 5: restart with sof at pixel (2,1)
    $display("[TB] test 5: mid-frame sof restart");
    fd0 = fd_count; win0 = win_count;
    for (int i = 0; i < 2*W + 1; i++) applyStimulus(1'b1, i == 0, DW'(100 + i));
    sendFrame(200, 1'b0);
    drain();
    checkOutput("t5_win_count", 32'(win_count - win0), 32'd4);
    checkOutput("t5_frame_done", 32'(fd_count - fd0), 32'd1);

    // Test 6: back-to-back frames, second sof right after the last pixel
    $display("[TB] test 6: back-to-back frames");
    fd0 = fd_count; win0 = win_count;
    sendFrame(0, 1'b0);
    sendFrame(50, 1'b0);
    drain();
    checkOutput("t6_win_count", 32'(win_count - win0), 32'd8);
    checkOutput("t6_frame_done", 32'(fd_count - fd0), 32'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
